seg7_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed multi-digit hexadecimal seven-segment display controller. Takes a packed vector of 4-bit digits plus per-digit decimal-point and blink masks, and scans them one digit at a time onto a shared segment bus with a one-hot digit select. Adds leading-zero suppression, blinking, frame-synchronous update (no tearing) and anti-ghost blanking. Sits between datapath/status registers and the board display pins.

---
 rtl/seg7_scan_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex seven-segment scanner with leading-zero suppression,
// per-digit blink, frame-synchronous update and anti-ghost blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_HALF     = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [6:0]            SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_BLANK  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_NONE  = SEL_ACTIVE_LOW ? '1 : '0;

  // Active-high glyphs, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    blink_off_q, blink_off_d;
  logic                    frame_pend_q, frame_pend_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                    pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    tick_q, tick_d;

  logic                    frame_start;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   sel_on;
  logic [3:0]              cur_digit;
  logic                    cur_dp, cur_blink, cur_supp, hide;
  logic [6:0]              seg_on;

  // Next-state: register capture, frame transfer, scan counters, output decode.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    fcnt_d       = fcnt_q;
    blink_off_d  = blink_off_q;
    frame_pend_d = frame_pend_q;
    pend_flag_d  = pend_flag_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_lz_d    = pend_lz_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    act_lz_d     = act_lz_q;
    zero_run     = 1'b1;
    supp         = '0;
    sel_on       = '0;
    cur_digit    = 4'h0;
    cur_dp       = 1'b0;
    cur_blink    = 1'b0;
    cur_supp     = 1'b0;

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blink_d = blink_mask;
      pend_lz_d    = lz_en;
      pend_flag_d  = 1'b1;
    end

    // frame_pend_q marks the (0,0) slot reached by a wrap, so the very first
    // post-reset frame never produces a tick or a transfer.
    frame_start = enable && frame_pend_q && (cnt_q == '0) && (idx_q == '0);

    if (frame_start) begin
      frame_pend_d = 1'b0;
      pend_flag_d  = 1'b0;
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dp_in;
        act_blink_d = blink_mask;
        act_lz_d    = lz_en;
      end else if (pend_flag_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        act_blink_d = pend_blink_q;
        act_lz_d    = pend_lz_q;
      end
      if (fcnt_q == FW'(BLINK_HALF - 1)) begin
        fcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    if (enable) begin
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_d        = '0;
          frame_pend_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      supp[i]  = act_lz_q && zero_run && (i != 0);
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = act_val_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blink = act_blink_q[i];
        cur_supp  = supp[i];
        sel_on[i] = 1'b1;
      end
    end

    hide   = blink_off_q && cur_blink;
    seg_on = (hide || cur_supp) ? 7'h00 : hex_glyph(cur_digit);

    seg_d  = SEG_BLANK;
    dp_d   = DP_BLANK;
    sel_d  = SEL_NONE;
    tick_d = frame_start;
    if (enable && (cnt_q != '0)) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      dp_d  = SEG_ACTIVE_LOW ? ~(cur_dp && !hide) : (cur_dp && !hide);
      sel_d = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      blink_off_q  <= 1'b0;
      frame_pend_q <= 1'b0;
      pend_flag_q  <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_lz_q    <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      act_lz_q     <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= DP_BLANK;
      sel_q        <= SEL_NONE;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      blink_off_q  <= blink_off_d;
      frame_pend_q <= frame_pend_d;
      pend_flag_q  <= pend_flag_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_lz_q    <= pend_lz_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      act_lz_q     <= act_lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 4 cycles per slot, 2-frame blink.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
  localparam logic [6:0] G8 = 7'h00, GA = 7'h08, GB = 7'h03, GC = 7'h46;
  localparam logic [6:0] GD = 7'h21;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int vectors = 0;
  int errors = 0;

  logic [6:0] cap_seg [16];
  logic       cap_dp [16];
  logic [3:0] cap_sel [16];
  logic       cap_tick [16];
  logic [6:0] es [4];
  logic [3:0] edp;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_HALF(2),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .value(value), .dp_in(dp_in), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
    value = v; dp_in = d; blink_mask = b; lz_en = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Steps at least once, stops at the sample where frame_tick is high.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (frame_tick === 1'b1) ok = 1'b1;
    end
  endtask

  // Records 16 consecutive samples starting at the current one.
  task automatic capture();
    for (int j = 0; j < 16; j++) begin
      cap_seg[j] = seg; cap_dp[j] = dp; cap_sel[j] = dig_sel; cap_tick[j] = frame_tick;
      if (j < 15) step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    vectors++;
    if (seg !== BLK || dp !== 1'b1 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: seg=%b dp=%b sel=%b tick=%b, expected %b 1 1111 0", seg, dp, dig_sel, frame_tick, BLK);
    end
    reset_n = 1'b1;
    step();
    vectors++;
    if (seg !== BLK || dp !== 1'b1 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_first: seg=%b dp=%b sel=%b tick=%b, expected %b 1 1111 0", seg, dp, dig_sel, frame_tick, BLK);
    end
    step();
    vectors++;
    if (seg !== G0 || dp !== 1'b1 || dig_sel !== 4'b1110 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_lit: seg=%b dp=%b sel=%b tick=%b, expected %b 1 1110 0", seg, dp, dig_sel, frame_tick, G0);
    end
  endtask

  task automatic test_decode();
    bit ok;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        es[0] = G4; es[1] = G3; es[2] = G2; es[3] = G1;
      end else begin
        do_load(16'hABCD, 4'b0100, 4'b0000, 1'b0);
        es[0] = GD; es[1] = GC; es[2] = GB; es[3] = GA;
      end
      edp = (p == 0) ? 4'b1111 : 4'b1011;
      wait_tick(ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL decode_tick: no frame_tick within 40 cycles, expected one"); end
      capture();
      for (int j = 0; j < 16; j++) begin
        logic [6:0] xs; logic xd; logic [3:0] xsel;
        xs = BLK; xd = 1'b1; xsel = 4'hF;
        if (j % 4 != 0) begin xs = es[j/4]; xd = edp[j/4]; xsel[j/4] = 1'b0; end
        vectors++;
        if (cap_seg[j] !== xs || cap_dp[j] !== xd || cap_sel[j] !== xsel || cap_tick[j] !== (j == 0)) begin
          errors++;
          $display("FAIL decode p%0d slot %0d: seg=%b dp=%b sel=%b tick=%b, expected %b %b %b %b",
                   p, j, cap_seg[j], cap_dp[j], cap_sel[j], cap_tick[j], xs, xd, xsel, (j == 0));
        end
      end
    end
  endtask

  task automatic test_lz();
    bit ok;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        do_load(16'h0050, 4'b1000, 4'b0000, 1'b1);
        es[0] = G0; es[1] = G5; es[2] = BLK; es[3] = BLK; edp = 4'b0111;
      end else if (p == 1) begin
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        es[0] = G0; es[1] = BLK; es[2] = BLK; es[3] = BLK; edp = 4'b1111;
      end else begin
        do_load(16'h0100, 4'b0000, 4'b0000, 1'b1);
        es[0] = G0; es[1] = G0; es[2] = G1; es[3] = BLK; edp = 4'b1111;
      end
      wait_tick(ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL lz_tick: no frame_tick within 40 cycles, expected one"); end
      capture();
      for (int j = 0; j < 16; j++) begin
        logic [6:0] xs; logic xd; logic [3:0] xsel;
        xs = BLK; xd = 1'b1; xsel = 4'hF;
        if (j % 4 != 0) begin xs = es[j/4]; xd = edp[j/4]; xsel[j/4] = 1'b0; end
        vectors++;
        if (cap_seg[j] !== xs || cap_dp[j] !== xd || cap_sel[j] !== xsel) begin
          errors++;
          $display("FAIL lz p%0d slot %0d: seg=%b dp=%b sel=%b, expected %b %b %b",
                   p, j, cap_seg[j], cap_dp[j], cap_sel[j], xs, xd, xsel);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    wait_tick(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL b2b_sync: no frame_tick within 40 cycles, expected one"); end
    step(); step(); step();
    value = 16'hAAAA; load = 1'b1; step(); load = 1'b0;
    step(); step();
    value = 16'hBBBB; load = 1'b1; step(); load = 1'b0;
    step(); step();
    vectors++;
    if (seg !== G2 || dig_sel !== 4'b1011) begin
      errors++;
      $display("FAIL b2b_old: seg=%b sel=%b, expected %b 1011", seg, dig_sel, G2);
    end
    wait_tick(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL b2b_tick: no frame_tick within 40 cycles, expected one"); end
    capture();
    for (int j = 0; j < 16; j++) begin
      logic [6:0] xs; logic [3:0] xsel;
      xs = BLK; xsel = 4'hF;
      if (j % 4 != 0) begin xs = GB; xsel[j/4] = 1'b0; end
      vectors++;
      if (cap_seg[j] !== xs || cap_sel[j] !== xsel || cap_dp[j] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_last_wins slot %0d: seg=%b sel=%b dp=%b, expected %b %b 1", j, cap_seg[j], cap_sel[j], cap_dp[j], xs, xsel);
      end
    end
    // Now in the (0,0) slot of the next frame: this load must bypass.
    value = 16'h5678; load = 1'b1; step(); load = 1'b0;
    capture();
    es[0] = G8; es[1] = G7; es[2] = G6; es[3] = G5;
    for (int j = 0; j < 16; j++) begin
      logic [6:0] xs; logic [3:0] xsel;
      xs = BLK; xsel = 4'hF;
      if (j % 4 != 0) begin xs = es[j/4]; xsel[j/4] = 1'b0; end
      vectors++;
      if (cap_seg[j] !== xs || cap_sel[j] !== xsel || cap_tick[j] !== (j == 0)) begin
        errors++;
        $display("FAIL b2b_bypass slot %0d: seg=%b sel=%b tick=%b, expected %b %b %b", j, cap_seg[j], cap_sel[j], cap_tick[j], xs, xsel, (j == 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_tick(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL rstmid_sync: no frame_tick within 40 cycles, expected one"); end
    for (int i = 0; i < 9; i++) step();
    reset_n = 1'b0;
    step();
    vectors++;
    if (seg !== BLK || dp !== 1'b1 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_blank: seg=%b dp=%b sel=%b tick=%b, expected %b 1 1111 0", seg, dp, dig_sel, frame_tick, BLK);
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 2) begin
        vectors++;
        if (seg !== G0 || dig_sel !== 4'b1110) begin
          errors++;
          $display("FAIL rstmid_restart: seg=%b sel=%b, expected %b 1110", seg, dig_sel, G0);
        end
      end
      if (e == 6) begin
        vectors++;
        if (seg !== G0 || dig_sel !== 4'b1101) begin
          errors++;
          $display("FAIL rstmid_idx1: seg=%b sel=%b, expected %b 1101", seg, dig_sel, G0);
        end
      end
      vectors++;
      if (frame_tick !== (e == 17)) begin
        errors++;
        $display("FAIL rstmid_tick edge %0d: tick=%b, expected %b", e, frame_tick, (e == 17));
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    wait_tick(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL en_sync: no frame_tick within 40 cycles, expected one"); end
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (seg !== BLK || dp !== 1'b1 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL en_off cycle %0d: seg=%b dp=%b sel=%b tick=%b, expected %b 1 1111 0", i, seg, dp, dig_sel, frame_tick, BLK);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [6:0] xs; logic [3:0] xsel;
      step();
      case (i)
        0, 1:    begin xs = G3;  xsel = 4'b1101; end
        2:       begin xs = BLK; xsel = 4'b1111; end
        default: begin xs = G2;  xsel = 4'b1011; end
      endcase
      vectors++;
      if (seg !== xs || dig_sel !== xsel) begin
        errors++;
        $display("FAIL en_resume cycle %0d: seg=%b sel=%b, expected %b %b", i, seg, dig_sel, xs, xsel);
      end
    end
  endtask

  task automatic test_blink();
    bit ok;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    do_load(16'h1234, 4'b0010, 4'b0010, 1'b0);
    for (int f = 0; f < 5; f++) begin
      bit vis;
      vis = (f == 0) || (f == 3) || (f == 4);
      wait_tick(ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL blink_tick f%0d: no frame_tick within 40 cycles, expected one", f); end
      capture();
      es[0] = G4; es[1] = vis ? G3 : BLK; es[2] = G2; es[3] = G1;
      edp = vis ? 4'b1101 : 4'b1111;
      for (int j = 0; j < 16; j++) begin
        logic [6:0] xs; logic xd; logic [3:0] xsel;
        xs = BLK; xd = 1'b1; xsel = 4'hF;
        if (j % 4 != 0) begin xs = es[j/4]; xd = edp[j/4]; xsel[j/4] = 1'b0; end
        vectors++;
        if (cap_seg[j] !== xs || cap_dp[j] !== xd || cap_sel[j] !== xsel) begin
          errors++;
          $display("FAIL blink f%0d slot %0d: seg=%b dp=%b sel=%b, expected %b %b %b",
                   f, j, cap_seg[j], cap_dp[j], cap_sel[j], xs, xd, xsel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_lz();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    test_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
